// File: rtl/stream_fifo_pkg.sv
// Shared width constants and sizing helpers for the raycaster pipeline FIFOs.
package stream_fifo_pkg;

    localparam int FIFO_DDA_IN_W  = 144;
    localparam int FIFO_DDA_OUT_W = 40;

    // Pointer width: enough to address DEPTH entries, never narrower than one bit.
    function automatic int ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Occupancy width: must be able to represent the value DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stream_fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
module stream_fifo_ram
    import stream_fifo_pkg::*;
#(
    parameter int WIDTH = 41,
    parameter int DEPTH = 256,
    parameter int AW    = ptr_w(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through valid/ready FIFO with tlast, packet mode, flush,
// programmable almost-full/almost-empty and high-water reporting.
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 40,
    parameter int DEPTH       = 256,
    parameter int PROG_FULL   = 12,
    parameter int PROG_EMPTY  = 4,
    parameter int PACKET_MODE = 0
) (
    input  logic                        clk_pixel,
    input  logic                        rst_in,
    input  logic                        flush_in,
    input  logic                        sender_valid_in,
    input  logic [DATA_WIDTH-1:0]       sender_data_in,
    input  logic                        sender_last_in,
    output logic                        fifo_ready_out,
    input  logic                        receiver_ready_in,
    output logic                        receiver_valid_out,
    output logic [DATA_WIDTH-1:0]       receiver_data_out,
    output logic                        receiver_last_out,
    output logic [cnt_w(DEPTH)-1:0]     count_out,
    output logic [cnt_w(DEPTH)-1:0]     hwm_out,
    output logic                        prog_full_out,
    output logic                        prog_empty_out
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d, pkt_cnt_q, pkt_cnt_d, hwm_q, hwm_d;
    logic          prog_full_q, prog_full_d, prog_empty_q, prog_empty_d;
    logic          push, pop, head_ok, head_last;
    logic [DATA_WIDTH-1:0] head_data;

    assign fifo_ready_out = (count_q < DEPTH_C);

    // In packet mode the head is held back until a whole packet is stored,
    // unless the FIFO is full (a packet longer than DEPTH would otherwise deadlock).
    assign head_ok            = (PACKET_MODE == 0) || (pkt_cnt_q != '0) || (count_q == DEPTH_C);
    assign receiver_valid_out = (count_q != '0) && head_ok;
    assign receiver_data_out  = head_data;
    assign receiver_last_out  = head_last && receiver_valid_out;

    assign push = sender_valid_in && fifo_ready_out;
    assign pop  = receiver_valid_out && receiver_ready_in;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        pkt_cnt_d = pkt_cnt_q;
        if (flush_in) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            pkt_cnt_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            end
            count_d   = count_q + CW'(push) - CW'(pop);
            pkt_cnt_d = pkt_cnt_q + CW'(push && sender_last_in) - CW'(pop && head_last);
        end
        hwm_d        = (count_d > hwm_q) ? count_d : hwm_q;
        prog_full_d  = ((DEPTH - int'(count_d)) <= PROG_FULL);
        prog_empty_d = (int'(count_d) <= PROG_EMPTY);
    end

    always_ff @(posedge clk_pixel) begin
        if (rst_in) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pkt_cnt_q    <= '0;
            hwm_q        <= '0;
            prog_full_q  <= (DEPTH <= PROG_FULL);
            prog_empty_q <= 1'b1;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            pkt_cnt_q    <= pkt_cnt_d;
            hwm_q        <= hwm_d;
            prog_full_q  <= prog_full_d;
            prog_empty_q <= prog_empty_d;
        end
    end

    assign count_out      = count_q;
    assign hwm_out        = hwm_q;
    assign prog_full_out  = prog_full_q;
    assign prog_empty_out = prog_empty_q;

    // tlast is stored as the MSB of each entry.
    stream_fifo_ram #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk_i   (clk_pixel),
        .we_i    (push && !flush_in),
        .waddr_i (wr_ptr_q),
        .wdata_i ({sender_last_in, sender_data_in}),
        .raddr_i (rd_ptr_q),
        .rdata_o ({head_last, head_data})
    );

endmodule

// File: tb/tb_stream_fifo.sv
// Five differently configured FIFOs, each checked every cycle against a queue model.
module tb_stream_fifo;

    localparam int NI = 5;

    function automatic int cfg_depth(input int i);
        case (i)
            0: return 4;
            1: return 8;
            2: return 4;
            3: return 8;
            default: return 6;
        endcase
    endfunction
    function automatic int cfg_pf(input int i);
        return (i == 4) ? 2 : 1;
    endfunction
    function automatic int cfg_pe(input int i);
        return 1;
    endfunction
    function automatic int cfg_pm(input int i);
        return (i == 1 || i == 2) ? 1 : 0;
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   started = 1'b0;

    logic        sv [NI];
    logic [39:0] sd [NI];
    logic        sl [NI];
    logic        rr [NI];
    logic        fl [NI];

    logic        rdy_o [NI];
    logic        vld_o [NI];
    logic [39:0] dat_o [NI];
    logic        lst_o [NI];
    logic [8:0]  cnt_o [NI];
    logic [8:0]  hwm_o [NI];
    logic        pf_o  [NI];
    logic        pe_o  [NI];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_inst
            localparam int D  = cfg_depth(gi);
            localparam int PF = cfg_pf(gi);
            localparam int PE = cfg_pe(gi);
            localparam int PM = cfg_pm(gi);
            localparam int CW = $clog2(D + 1);

            logic          ready, valid, last, pf, pe;
            logic [39:0]   data;
            logic [CW-1:0] cnt, hwm;

            stream_fifo #(
                .DATA_WIDTH (40),
                .DEPTH      (D),
                .PROG_FULL  (PF),
                .PROG_EMPTY (PE),
                .PACKET_MODE(PM)
            ) u_dut (
                .clk_pixel         (clk),
                .rst_in            (rst),
                .flush_in          (fl[gi]),
                .sender_valid_in   (sv[gi]),
                .sender_data_in    (sd[gi]),
                .sender_last_in    (sl[gi]),
                .fifo_ready_out    (ready),
                .receiver_ready_in (rr[gi]),
                .receiver_valid_out(valid),
                .receiver_data_out (data),
                .receiver_last_out (last),
                .count_out         (cnt),
                .hwm_out           (hwm),
                .prog_full_out     (pf),
                .prog_empty_out    (pe)
            );

            assign rdy_o[gi] = ready;
            assign vld_o[gi] = valid;
            assign dat_o[gi] = data;
            assign lst_o[gi] = last;
            assign cnt_o[gi] = 9'(cnt);
            assign hwm_o[gi] = 9'(hwm);
            assign pf_o[gi]  = pf;
            assign pe_o[gi]  = pe;

            // Model: queue of {last, data}; the receiver may see the head when the
            // queue holds a complete packet anywhere in it, or when it is full.
            logic [40:0] q[$];
            int hwm_m = 0;

            function automatic bit m_valid();
                bit has_last = 1'b0;
                foreach (q[i]) if (q[i][40]) has_last = 1'b1;
                return (q.size() != 0) && (PM == 0 || has_last || q.size() == D);
            endfunction

            always @(posedge clk) begin
                bit pu, po;
                if (rst) begin
                    q.delete();
                    hwm_m = 0;
                end else begin
                    pu = sv[gi] && (q.size() < D);
                    po = m_valid() && rr[gi];
                    if (fl[gi]) begin
                        q.delete();
                    end else begin
                        if (po) void'(q.pop_front());
                        if (pu) q.push_back({sl[gi], sd[gi]});
                    end
                    if (q.size() > hwm_m) hwm_m = q.size();
                end
            end

            always @(negedge clk) begin
                if (started) begin
                    chk($sformatf("i%0d.ready", gi), 64'(ready), 64'(q.size() < D));
                    chk($sformatf("i%0d.valid", gi), 64'(valid), 64'(m_valid()));
                    if (m_valid()) begin
                        chk($sformatf("i%0d.data", gi), 64'(data), 64'(q[0][39:0]));
                        chk($sformatf("i%0d.last", gi), 64'(last), 64'(q[0][40]));
                    end
                    chk($sformatf("i%0d.count", gi), 64'(cnt), 64'(q.size()));
                    chk($sformatf("i%0d.hwm", gi), 64'(hwm), 64'(hwm_m));
                    chk($sformatf("i%0d.pfull", gi), 64'(pf), 64'((D - q.size()) <= PF));
                    chk($sformatf("i%0d.pempty", gi), 64'(pe), 64'(q.size() <= PE));
                end
            end
        end
    endgenerate

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            sv[i] = 0; sd[i] = '0; sl[i] = 0; rr[i] = 0; fl[i] = 0;
        end
        step();
        started = 1'b1;
        rst = 1'b0;
        step();

        // Fill DEPTH=4 with the receiver stalled, then drain in order.
        for (int k = 0; k < 4; k++) begin
            sv[0] = 1; sd[0] = 40'hA0 + 40'(k); step();
        end
        sv[0] = 0;
        chk("t1.ready", 64'(rdy_o[0]), 0);
        chk("t1.count", 64'(cnt_o[0]), 4);
        chk("t1.hwm", 64'(hwm_o[0]), 4);
        rr[0] = 1;
        for (int k = 0; k < 4; k++) begin
            chk("t1.order", 64'(dat_o[0]), 64'(40'hA0 + 40'(k)));
            step();
        end
        chk("t1.empty", 64'(vld_o[0]), 0);

        // Single beat into empty FIFO is visible one cycle later; then streaming.
        rr[0] = 0; sv[0] = 1; sd[0] = 40'h12345; step();
        sv[0] = 0;
        chk("t2.valid", 64'(vld_o[0]), 1);
        chk("t2.data", 64'(dat_o[0]), 64'h12345);
        sv[0] = 1; rr[0] = 1;
        for (int k = 0; k < 6; k++) begin
            sd[0] = 40'(k); step();
            chk("t2.steady", 64'(cnt_o[0]), 1);
        end
        sv[0] = 0; step(); rr[0] = 0;

        // Packet mode: nothing visible until the tlast beat is stored.
        rr[1] = 1;
        for (int k = 0; k < 3; k++) begin
            sv[1] = 1; sd[1] = 40'hB0 + 40'(k); sl[1] = (k == 2); step();
            if (k < 2) chk("t3.hold", 64'(vld_o[1]), 0);
        end
        sv[1] = 0; sl[1] = 0;
        for (int k = 0; k < 3; k++) begin
            chk("t3.valid", 64'(vld_o[1]), 1);
            chk("t3.data", 64'(dat_o[1]), 64'(40'hB0 + 40'(k)));
            chk("t3.last", 64'(lst_o[1]), 64'(k == 2));
            step();
        end
        chk("t3.done", 64'(vld_o[1]), 0);

        // Packet mode full escape on DEPTH=4.
        rr[2] = 1;
        for (int k = 0; k < 4; k++) begin
            sv[2] = 1; sd[2] = 40'hC0 + 40'(k); step();
            if (k < 3) chk("t4.hold", 64'(vld_o[2]), 0);
        end
        sv[2] = 0;
        chk("t4.escape", 64'(vld_o[2]), 1);
        chk("t4.data0", 64'(dat_o[2]), 64'hC0);
        step();
        chk("t4.rehold", 64'(vld_o[2]), 0);
        sv[2] = 1; sl[2] = 1; sd[2] = 40'hCE; step();
        sv[2] = 0; sl[2] = 0;
        for (int k = 1; k < 5; k++) begin
            chk("t4.drain", 64'(dat_o[2]), (k < 4) ? 64'(40'hC0 + 40'(k)) : 64'hCE);
            chk("t4.last", 64'(lst_o[2]), 64'(k == 4));
            step();
        end

        // Flush discards contents and the concurrent push; hwm survives.
        for (int k = 0; k < 5; k++) begin
            sv[3] = 1; sd[3] = 40'hD0 + 40'(k); step();
        end
        fl[3] = 1; step();
        fl[3] = 0; sv[3] = 0;
        chk("t5.count", 64'(cnt_o[3]), 0);
        chk("t5.valid", 64'(vld_o[3]), 0);
        chk("t5.hwm", 64'(hwm_o[3]), 5);

        // Non power-of-two depth: prog flags, then random traffic across all instances.
        for (int k = 0; k < 5; k++) begin
            sv[4] = 1; sd[4] = 40'hE0 + 40'(k); step();
        end
        sv[4] = 0;
        chk("t6.pfull", 64'(pf_o[4]), 1);
        chk("t6.pempty", 64'(pe_o[4]), 0);
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NI; i++) begin
                sv[i] = ($urandom_range(0, 2) != 0);
                rr[i] = ($urandom_range(0, 2) != 0);
                sd[i] = {8'($urandom), $urandom};
                sl[i] = ($urandom_range(0, 3) == 0);
                fl[i] = ($urandom_range(0, 49) == 0);
            end
            step();
        end
        for (int i = 0; i < NI; i++) begin
            sv[i] = 1; rr[i] = 0; fl[i] = 0;
        end
        step();

        // Reset mid-stream.
        rst = 1; step();
        rst = 0;
        for (int i = 0; i < NI; i++) sv[i] = 0;
        chk("t6.rst.ready", 64'(rdy_o[4]), 1);
        chk("t6.rst.valid", 64'(vld_o[4]), 0);
        chk("t6.rst.last", 64'(lst_o[4]), 0);
        chk("t6.rst.count", 64'(cnt_o[4]), 0);
        chk("t6.rst.hwm", 64'(hwm_o[4]), 0);
        chk("t6.rst.pfull", 64'(pf_o[4]), 0);
        chk("t6.rst.pempty", 64'(pe_o[4]), 1);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
